// File: rtl/ifetch_pkg.sv
// ifetch_pkg: shared widths and FSM state type for the instruction-fetch responder
package ifetch_pkg;
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_REQ  = 2'd1;
  localparam logic [1:0] ST_DATA = 2'd2;
  localparam logic [1:0] ST_RESP = 2'd3;
  localparam int IFETCH_LINE_W = 512;
  localparam int IFETCH_BEATS  = 8;
  localparam int IFETCH_IDX_W  = 19;
  typedef enum logic [1:0] {
    S_IDLE = ST_IDLE,
    S_REQ  = ST_REQ,
    S_DATA = ST_DATA,
    S_RESP = ST_RESP
  } state_e;
endpackage

// File: rtl/ifetch_line_assembler.sv
// ifetch_line_assembler: counts DDR beats and writes each one into its slot of the line register
module ifetch_line_assembler #(
  parameter int BEATS = 8,
  parameter int DW    = 64
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  clr_i,
  input  logic                  we_i,
  input  logic [DW-1:0]         data_i,
  output logic [BEATS*DW-1:0]   line_o,
  output logic                  last_beat_o
);
  localparam int KW = $clog2(BEATS);
  logic [KW-1:0]       k_q, k_d;
  logic [BEATS*DW-1:0] line_q;
  assign k_d         = clr_i ? '0 : (we_i ? k_q + 1'b1 : k_q);
  assign last_beat_o = k_q == KW'(BEATS - 1);
  assign line_o      = line_q;
  // beat counter plus beat-indexed write; the line is never cleared so it stays readable after delivery
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) begin
      k_q    <= '0;
      line_q <= '0;
    end else begin
      k_q <= k_d;
      if (we_i) line_q[k_q*DW +: DW] <= data_i;
    end
endmodule

// File: rtl/ifetch_ddr_responder.sv
// ifetch_ddr_responder: accepts a fetch index, bursts a line from DDR and hands it to the ibuffer; IFETCH_TIMEOUT_EN adds an idle-beat watchdog
module ifetch_ddr_responder
  import ifetch_pkg::*;
#(
  parameter int BEATS          = IFETCH_BEATS,
  parameter int DDR_DW         = IFETCH_LINE_W / IFETCH_BEATS,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                      clock,
  input  logic                      reset_n,
  input  logic                      pc_index_valid,
  input  logic [IFETCH_IDX_W-1:0]   pc_index,
  output logic                      pc_index_ready,
  input  logic                      cancel_pc_fetch,
  output logic                      pc_operation_done,
  output logic                      ddr_req_valid,
  input  logic                      ddr_req_ready,
  output logic [IFETCH_IDX_W-1:0]   ddr_addr,
  output logic [3:0]                ddr_burst_len,
  input  logic                      ddr_rvalid,
  input  logic [DDR_DW-1:0]         ddr_rdata,
  output logic                      line_valid,
  output logic [BEATS*DDR_DW-1:0]   line_data,
  output logic                      fetch_error
);
  state_e                  state_q, state_d;
  logic [IFETCH_IDX_W-1:0] idx_q;
  logic                    cancel_q, accept, beat, last_beat, timeout, err;
  assign accept = state_q == S_IDLE && pc_index_valid;
  assign beat   = state_q == S_DATA && ddr_rvalid;
  ifetch_line_assembler #(.BEATS(BEATS), .DW(DDR_DW)) u_asm (
    .clock       (clock),
    .reset_n     (reset_n),
    .clr_i       (accept),
    .we_i        (beat),
    .data_i      (ddr_rdata),
    .line_o      (line_data),
    .last_beat_o (last_beat)
  );
`ifdef IFETCH_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES) > 10 ? $clog2(TIMEOUT_CYCLES) : 10;
  logic [TW-1:0] cnt_q;
  logic          err_q, stall;
  assign stall   = (state_q == S_REQ && !ddr_req_ready) || (state_q == S_DATA && !ddr_rvalid);
  assign timeout = stall && cnt_q == TW'(TIMEOUT_CYCLES - 1);
  assign err     = err_q;
  // consecutive stalled cycles; a request handshake or any beat restarts the count
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      cnt_q <= stall ? cnt_q + 1'b1 : '0;
      err_q <= accept ? 1'b0 : (timeout ? 1'b1 : err_q);
    end
`else
  assign timeout = 1'b0;
  assign err     = 1'b0;
`endif
  // next state and state-decoded outputs; a cancel arriving in RESP still kills that cycle's line
  always_comb begin
    state_d           = state_q;
    pc_index_ready    = state_q == S_IDLE;
    ddr_req_valid     = state_q == S_REQ;
    pc_operation_done = state_q == S_RESP;
    line_valid        = state_q == S_RESP && !cancel_q && !cancel_pc_fetch && !err;
    fetch_error       = state_q == S_RESP && err;
    ddr_addr          = idx_q;
    ddr_burst_len     = 4'(BEATS - 1);
    case (state_q)
      S_IDLE:  state_d = pc_index_valid ? S_REQ : S_IDLE;
      S_REQ:   state_d = ddr_req_ready ? S_DATA : (timeout ? S_RESP : S_REQ);
      S_DATA:  state_d = (beat && last_beat) || timeout ? S_RESP : S_DATA;
      default: state_d = S_IDLE;
    endcase
  end
  // state, latched fetch index and sticky cancel for the in-flight fetch
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) begin
      state_q  <= S_IDLE;
      idx_q    <= '0;
      cancel_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      if (accept) idx_q <= pc_index;
      cancel_q <= accept ? 1'b0 : (cancel_q || (state_q != S_IDLE && cancel_pc_fetch));
    end
endmodule

// File: tb/tb_ifetch_ddr_responder.sv
// tb_ifetch_ddr_responder: randomized fetch transactions checked against a line/timing model
module tb_ifetch_ddr_responder;
  localparam int TO = 16;
  logic         clock = 0, reset_n = 1, pc_index_valid = 0, cancel_pc_fetch = 0;
  logic         ddr_req_ready = 0, ddr_rvalid = 0;
  logic [18:0]  pc_index = 0;
  logic [63:0]  ddr_rdata = 0;
  logic         pc_index_ready, pc_operation_done, ddr_req_valid, line_valid, fetch_error;
  logic [18:0]  ddr_addr;
  logic [3:0]   ddr_burst_len;
  logic [511:0] line_data;
  int           checks = 0, failures = 0;
  logic [63:0]  beat_v [8];
  int           bc [8];
  logic [511:0] exp_line, o_line, o_line_end;
  logic [18:0]  o_addr;
  logic [3:0]   o_blen;
  logic         o_rdy0;
  int           o_req_c, o_done, o_done_c, o_lv, o_err, o_rdy_bad, o_rdy_after, o_addr_bad;

  ifetch_ddr_responder #(.TIMEOUT_CYCLES(TO)) dut (
    .clock(clock), .reset_n(reset_n), .pc_index_valid(pc_index_valid), .pc_index(pc_index),
    .pc_index_ready(pc_index_ready), .cancel_pc_fetch(cancel_pc_fetch),
    .pc_operation_done(pc_operation_done), .ddr_req_valid(ddr_req_valid),
    .ddr_req_ready(ddr_req_ready), .ddr_addr(ddr_addr), .ddr_burst_len(ddr_burst_len),
    .ddr_rvalid(ddr_rvalid), .ddr_rdata(ddr_rdata), .line_valid(line_valid),
    .line_data(line_data), .fetch_error(fetch_error)
  );

  always #5 clock = ~clock;

  // One fetch: inputs driven at each negedge, outputs sampled 1 ns later. Cycle c counts from the accept cycle (c=0).
  task automatic do_fetch(input logic [18:0] idx, input int req_dly, input int gmin, input int gmax,
                          input int stop_after, input int cancel_after, input bit cancel_resp,
                          input int rst_after, input bit seq);
    int fin;
    for (int i = 0; i < 8; i++) beat_v[i] = seq ? 64'(i) : {$urandom, $urandom};
    exp_line = {beat_v[7], beat_v[6], beat_v[5], beat_v[4], beat_v[3], beat_v[2], beat_v[1], beat_v[0]};
    bc[0] = 2 + req_dly + ((gmin < 1) ? 1 : int'($urandom_range(gmax, gmin)));
    for (int i = 1; i < 8; i++) bc[i] = bc[i-1] + 1 + int'($urandom_range(gmax, gmin));
    fin = (stop_after == 8 && rst_after < 0) ? bc[7] + 3 : bc[stop_after-1] + TO + 4;
    o_req_c = -1; o_done = 0; o_done_c = -1; o_lv = 0; o_err = 0;
    o_rdy_bad = 0; o_rdy_after = -1; o_addr_bad = 0; o_line = '0; o_addr = '0; o_blen = '0;
    @(negedge clock);
    pc_index_valid = 1; pc_index = idx;
    #1 o_rdy0 = pc_index_ready;
    for (int c = 1; c <= fin; c++) begin
      @(negedge clock);
      pc_index_valid = 0; pc_index = 19'($urandom);
      ddr_req_ready = (c == 1 + req_dly);
      ddr_rvalid = 0; ddr_rdata = {$urandom, $urandom};
      for (int i = 0; i < stop_after; i++) if (c == bc[i]) begin ddr_rvalid = 1; ddr_rdata = beat_v[i]; end
      if (req_dly > 0 && c == 1) ddr_rvalid = 1;
      cancel_pc_fetch = (cancel_after >= 0 && c == bc[cancel_after] + 1) || (cancel_resp && c == bc[7] + 1);
      if (rst_after >= 0 && c == bc[rst_after] + 1) reset_n = 0;
      if (rst_after >= 0 && c == bc[rst_after] + 2) reset_n = 1;
      #1;
      if (ddr_req_valid && o_req_c < 0) begin o_req_c = c; o_addr = ddr_addr; o_blen = ddr_burst_len; end
      if (ddr_req_valid && ddr_addr !== idx) o_addr_bad++;
      if (pc_operation_done) begin o_done++; o_done_c = c; o_line = line_data; o_err += int'(fetch_error); end
      if (line_valid) o_lv++;
      if (pc_index_ready && (o_done == 0 || c == o_done_c)) o_rdy_bad++;
      if (o_done_c >= 0 && c == o_done_c + 1) o_rdy_after = int'(pc_index_ready);
    end
    ddr_rvalid = 0; ddr_req_ready = 0; cancel_pc_fetch = 0;
    o_line_end = line_data;
  endtask

  task automatic test_reset;
    #2 reset_n = 0;
    repeat (3) @(negedge clock);
    #1;
    checks++; if (pc_index_ready !== 1'b1) begin failures++; $display("FAIL reset_ready got=%b exp=1", pc_index_ready); end
    checks++; if ({pc_operation_done, ddr_req_valid, line_valid, fetch_error} !== 4'b0) begin failures++; $display("FAIL reset_outs got=%b exp=0000", {pc_operation_done, ddr_req_valid, line_valid, fetch_error}); end
    checks++; if (line_data !== '0) begin failures++; $display("FAIL reset_line got=%h exp=0", line_data); end
    checks++; if (ddr_addr !== '0) begin failures++; $display("FAIL reset_addr got=%h exp=0", ddr_addr); end
    @(negedge clock); reset_n = 1;
  endtask

  task automatic test_basic;
    do_fetch(19'h00010, 0, 0, 0, 8, -1, 0, -1, 1);
    checks++; if (o_rdy0 !== 1'b1) begin failures++; $display("FAIL basic_ready got=%b exp=1", o_rdy0); end
    checks++; if (o_req_c !== 1) begin failures++; $display("FAIL basic_req_cycle got=%0d exp=1", o_req_c); end
    checks++; if (o_addr !== 19'h00010) begin failures++; $display("FAIL basic_addr got=%h exp=00010", o_addr); end
    checks++; if (o_blen !== 4'd7) begin failures++; $display("FAIL basic_blen got=%0d exp=7", o_blen); end
    checks++; if (o_done !== 1 || o_done_c !== 11) begin failures++; $display("FAIL basic_done count=%0d cycle=%0d exp 1 at 11", o_done, o_done_c); end
    checks++; if (o_lv !== 1) begin failures++; $display("FAIL basic_line_valid got=%0d exp=1", o_lv); end
    checks++; if (o_line[63:0] !== 64'd0 || o_line[511:448] !== 64'd7) begin failures++; $display("FAIL basic_edges lo=%h hi=%h exp 0/7", o_line[63:0], o_line[511:448]); end
    checks++; if (o_line !== exp_line) begin failures++; $display("FAIL basic_line got=%h exp=%h", o_line, exp_line); end
    checks++; if (o_rdy_bad !== 0 || o_rdy_after !== 1) begin failures++; $display("FAIL basic_ready_window busy_hi=%0d after=%0d exp 0/1", o_rdy_bad, o_rdy_after); end
    checks++; if (o_err !== 0) begin failures++; $display("FAIL basic_err got=%0d exp=0", o_err); end
    checks++; if (o_line_end !== exp_line) begin failures++; $display("FAIL basic_line_hold got=%h exp=%h", o_line_end, exp_line); end
  endtask

  task automatic test_gapped;
    for (int n = 0; n < 3; n++) begin
      logic [18:0] idx;
      idx = 19'($urandom);
      do_fetch(idx, 5, 1, 3, 8, -1, 0, -1, 0);
      checks++; if (o_req_c !== 1 || o_addr_bad !== 0) begin failures++; $display("FAIL gap_addr req_c=%0d unstable=%0d exp 1/0", o_req_c, o_addr_bad); end
      checks++; if (o_done !== 1 || o_done_c !== bc[7] + 1) begin failures++; $display("FAIL gap_done count=%0d cycle=%0d exp 1 at %0d", o_done, o_done_c, bc[7] + 1); end
      checks++; if (o_lv !== 1 || o_line !== exp_line) begin failures++; $display("FAIL gap_line lv=%0d got=%h exp=%h", o_lv, o_line, exp_line); end
    end
  endtask

  task automatic test_cancel_mid;
    do_fetch(19'($urandom), 0, 0, 2, 8, 3, 0, -1, 0);
    checks++; if (o_done !== 1 || o_done_c !== bc[7] + 1) begin failures++; $display("FAIL cancel_mid_done count=%0d cycle=%0d exp 1 at %0d", o_done, o_done_c, bc[7] + 1); end
    checks++; if (o_lv !== 0) begin failures++; $display("FAIL cancel_mid_lv got=%0d exp=0", o_lv); end
    do_fetch(19'($urandom), 0, 0, 1, 8, -1, 0, -1, 0);
    checks++; if (o_lv !== 1 || o_line !== exp_line) begin failures++; $display("FAIL cancel_next lv=%0d got=%h exp=%h", o_lv, o_line, exp_line); end
  endtask

  task automatic test_cancel_resp;
    do_fetch(19'($urandom), 0, 0, 1, 8, -1, 1, -1, 0);
    checks++; if (o_done !== 1 || o_lv !== 0) begin failures++; $display("FAIL cancel_resp done=%0d lv=%0d exp 1/0", o_done, o_lv); end
    checks++; if (o_line !== exp_line) begin failures++; $display("FAIL cancel_resp_line got=%h exp=%h", o_line, exp_line); end
    @(negedge clock); cancel_pc_fetch = 1;
    @(negedge clock); cancel_pc_fetch = 0;
    do_fetch(19'($urandom), 0, 0, 1, 8, -1, 0, -1, 0);
    checks++; if (o_done !== 1 || o_lv !== 1) begin failures++; $display("FAIL cancel_idle done=%0d lv=%0d exp 1/1", o_done, o_lv); end
  endtask

  task automatic test_reset_mid;
    do_fetch(19'($urandom), 0, 0, 1, 8, -1, 0, 2, 0);
    checks++; if (o_done !== 0 || o_lv !== 0) begin failures++; $display("FAIL rst_mid done=%0d lv=%0d exp 0/0", o_done, o_lv); end
    checks++; if (pc_index_ready !== 1'b1) begin failures++; $display("FAIL rst_mid_ready got=%b exp=1", pc_index_ready); end
    checks++; if (o_line_end !== '0) begin failures++; $display("FAIL rst_mid_line got=%h exp=0", o_line_end); end
    do_fetch(19'($urandom), 0, 0, 1, 8, -1, 0, -1, 0);
    checks++; if (o_lv !== 1 || o_line !== exp_line) begin failures++; $display("FAIL rst_recover lv=%0d got=%h exp=%h", o_lv, o_line, exp_line); end
  endtask

  task automatic test_back_to_back;
    for (int n = 0; n < 4; n++) begin
      do_fetch(19'($urandom), 0, 0, 0, 8, -1, 0, -1, 0);
      checks++; if (o_done !== 1 || o_done_c !== bc[7] + 1 || o_rdy_after !== 1) begin failures++; $display("FAIL b2b_timing count=%0d cycle=%0d ready_after=%0d exp 1 at %0d ready 1", o_done, o_done_c, o_rdy_after, bc[7] + 1); end
      checks++; if (o_lv !== 1 || o_line !== exp_line) begin failures++; $display("FAIL b2b_line lv=%0d got=%h exp=%h", o_lv, o_line, exp_line); end
    end
  endtask

  task automatic test_timeout;
    do_fetch(19'($urandom), 0, 0, 1, 5, -1, 0, -1, 0);
`ifdef IFETCH_TIMEOUT_EN
    checks++; if (o_done !== 1 || o_done_c !== bc[4] + TO + 1) begin failures++; $display("FAIL timeout_done count=%0d cycle=%0d exp 1 at %0d", o_done, o_done_c, bc[4] + TO + 1); end
    checks++; if (o_err !== 1 || o_lv !== 0) begin failures++; $display("FAIL timeout_err err=%0d lv=%0d exp 1/0", o_err, o_lv); end
`else
    checks++; if (o_done !== 0 || o_err !== 0) begin failures++; $display("FAIL no_timeout done=%0d err=%0d exp 0/0", o_done, o_err); end
    checks++; if (pc_index_ready !== 1'b0) begin failures++; $display("FAIL no_timeout_busy ready=%b exp=0", pc_index_ready); end
    @(negedge clock); reset_n = 0;
    @(negedge clock); reset_n = 1;
    #1;
    checks++; if (pc_index_ready !== 1'b1) begin failures++; $display("FAIL no_timeout_reset ready=%b exp=1", pc_index_ready); end
`endif
  endtask

  initial begin
    test_reset;
    test_basic;
    test_gapped;
    test_cancel_mid;
    test_cancel_resp;
    test_reset_mid;
    test_back_to_back;
    test_timeout;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/ifetch_ddr_responder.md
# ifetch_ddr_responder

Responder end of the fetch-request handshake driven by `pc_ctrl`. It accepts one fetch index per transaction, issues a single burst read to the DDR port, and assembles the returned beats into a 64-byte instruction line. It then returns the line to the ibuffer and pulses `pc_operation_done`. It sits inside `channel_arb` on the instruction channel. A cancel input suppresses line delivery for a fetch made stale by a redirect.

## Interface
- `BEATS`, 8: DDR beats per line.
- `DDR_DW`, 64: DDR read data width in bits. The line width is `BEATS*DDR_DW` = 512.
- `TIMEOUT_CYCLES`, 1024: idle-beat watchdog limit. Used only with `IFETCH_TIMEOUT_EN`.
- `clock  in  1`: single clock, rising edge.
- `reset_n  in  1`: asynchronous, active-low reset.
- `pc_index_valid  in  1`: fetch request from `pc_ctrl`.
- `pc_index  in  19`: PC[21:3], 8-byte granular start index.
- `pc_index_ready  out  1`: request accepted when valid&&ready.
- `cancel_pc_fetch  in  1`: the in-flight fetch is stale.
- `pc_operation_done  out  1`: one-cycle pulse, exactly once per accepted request.
- `ddr_req_valid  out  1`: DDR burst read request.
- `ddr_req_ready  in  1`: DDR accepts the request.
- `ddr_addr  out  19`: burst start index, equal to the latched `pc_index`.
- `ddr_burst_len  out  4`: constant `BEATS-1`.
- `ddr_rvalid  in  1`: read beat valid. There is no backpressure.
- `ddr_rdata  in  DDR_DW`: read beat.
- `line_valid  out  1`: one-cycle pulse carrying the line to the ibuffer.
- `line_data  out  512`: assembled line.
- `fetch_error  out  1`: pulse with `pc_operation_done` on timeout. Tied 0 without `IFETCH_TIMEOUT_EN`.

## Operation
- **States:** IDLE, REQ, DATA, RESP.
- **IDLE:**
  - `pc_index_ready`=1, combinational from the state.
  - On valid&&ready: latch `pc_index`, clear `cancel_q`, clear the beat counter, then go to REQ.
- **REQ:**
  - `ddr_req_valid`=1 and `ddr_addr` holds steady until `ddr_req_ready`.
  - On the handshake, go to DATA.
- **DATA:**
  - Each `ddr_rvalid` writes `ddr_rdata` into `line_data[64k+63:64k]`, where k is the beat counter (3 bits), then increments k.
  - When beat k=`BEATS-1` is taken, go to RESP.
- **RESP (one cycle):**
  - `pc_operation_done`=1.
  - `line_valid`=1 only if `cancel_q`=0.
  - Then go to IDLE.
- **Cancel:**
  - `cancel_q` is set by `cancel_pc_fetch`=1 in any cycle while in REQ, DATA or RESP. A cancel seen in RESP suppresses that cycle's `line_valid` combinationally.
  - A cancelled fetch still completes its DDR burst, which is never aborted, and still pulses `pc_operation_done`.
  - `cancel_pc_fetch` in IDLE is ignored.
- **Stray inputs:** `ddr_rvalid` outside DATA is ignored. There are no extra beats after the last one.
- **Reset values:** `pc_index_ready`=1, all other outputs 0, `line_data`=0, state IDLE.
- **Reset mid-operation:** abort to IDLE with no done pulse. Beats still in flight are dropped because they are ignored in IDLE.

## Timing
- Request accepted at cycle T → `ddr_req_valid` high at T+1.
- Last beat at cycle B → `pc_operation_done`/`line_valid` at B+1.
- Minimum round trip with ready and beats back-to-back is 1 + 1 + `BEATS` + 1 cycles.
- `pc_index_ready` is low from T+1 until the cycle after RESP, so a new request is accepted no earlier than RESP+1.
- `line_data` is stable from RESP until the next accepted request's first beat.

## Configuration
- **`IFETCH_TIMEOUT_EN` defined:**
  - A 10-bit-min counter (`$clog2(TIMEOUT_CYCLES)`) counts consecutive DATA cycles without `ddr_rvalid`, and resets on each beat.
  - When it reaches `TIMEOUT_CYCLES`, go to RESP with `fetch_error`=1 and `line_valid`=0.
  - The counter also runs in REQ while waiting for `ddr_req_ready`.
- **`IFETCH_TIMEOUT_EN` undefined:** no counter, `fetch_error`=0, and the block waits indefinitely.

## Structure
- **`ifetch_pkg`:**
  - state localparams for IDLE/REQ/DATA/RESP;
  - `IFETCH_LINE_W`=512;
  - `IFETCH_BEATS`=8;
  - `IFETCH_IDX_W`=19.
- **Sub-module `ifetch_line_assembler`:** beat counter, beat-indexed write into the line register, and a `last_beat` output.
- The FSM, cancel flag and watchdog stay in the top module.

## Test plan
- **Basic fetch:** index 0x00010, DDR ready immediately, beats 0x0..0x7 back-to-back → `ddr_addr`=0x00010 at T+1, `line_valid`+done at T+11, `line_data[63:0]`=0, `[511:448]`=7.
- **Gapped beats:** `ddr_req_ready` delayed 5 cycles, random 1–3 cycle gaps between beats → correct beat placement and exactly one done pulse.
- **Cancel mid-burst:** `cancel_pc_fetch` pulsed after beat 3 → all 8 beats consumed, done=1, `line_valid`=0. The next request delivers its line normally.
- **Cancel in the RESP cycle:** cancel asserted in the same cycle as done → `line_valid`=0. Cancel asserted in IDLE → no effect.
- **Reset mid-op:** `reset_n` low during DATA after beat 2, then remaining beats arrive → no done, no `line_valid`, and `pc_index_ready`=1.
- **Timeout (`IFETCH_TIMEOUT_EN`, `TIMEOUT_CYCLES`=16):** stop beats after beat 4 → `fetch_error`+done at cycle 16 with no beat, `line_valid`=0. Without the macro, the block stays in DATA.
